alu_dispatch: RTL and testbench
===============================

# alu_dispatch

Issue stage for the two-slot ALU reservation station. It accepts one decoded ALU instruction per cycle over a valid/ready handshake and reads operands from an internal 32-entry register file and tag table. It allocates a free RS slot, marks the destination register with that slot's tag, and drives the per-slot `en`/op/tag/data issue bus. It also snoops the ALU0, ALU1 and LS writeback broadcasts to retire register tags and to forward same-cycle results into issued operands.

## Interface
- `OP_W`, 6, width of the internal op (`sinst_t`).
- Tag encoding, fixed, 2 bits: UNLOCKED=0, ALU0=1, ALU1=2, LS=3.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; when low, no state changes and `in_ready`=0.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  combinational; instruction accepted this cycle when `in_valid`&&`in_ready`.
- `in_pc`  in  32  instruction pc.
- `in_op`  in  OP_W  ALU op.
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  register addresses.
- `in_imm`  in  32  immediate.
- `in_use_imm`  in  1  operand y is `in_imm` rather than `rs2`.
- `slot_busy0`, `slot_busy1`  in  1 each  RS slot occupied.
- `wb_alu0_valid`, `wb_alu0_data`  in  1/32  ALU0 result broadcast (tag 1).
- `wb_alu1_valid`, `wb_alu1_data`  in  1/32  ALU1 result broadcast (tag 2).
- `wb_ls_valid`, `wb_ls_data`  in  1/32  LS result broadcast (tag 3).
- `ls_lock_valid`, `ls_lock_rd`  in  1/5  LS unit claims register `ls_lock_rd` (tag 3).
- Per slot k∈{0,1}: `en_k` out 1, `pc_k` out 32, `op_k` out OP_W, `tagx_k`/`tagy_k`/`tagw_k` out 2, `datax_k`/`datay_k` out 32, `addrw_k` out 5; all registered.

## Operation
- State: `regs[0:31]` (32b), `tag[0:31]` (2b), issue output registers.
- Slot k is free when `slot_busy_k`=0 and `en_k`=0 (covers the cycle before RS busy rises).
- `in_ready` = `rdy` && !`rst` && (slot0 free || slot1 free). Slot 0 is chosen if free, otherwise slot 1.
- On accept into slot k, next cycle:
  - `en_k`=1, `pc_k`=`in_pc`, `op_k`=`in_op`, `addrw_k`=`in_rd`, `tagw_k`=k+1.
- Operand x from `rs1`:
  - If `rs1`=0 → tag 0, data 0.
  - Else if `tag[rs1]`=0 → tag 0, data `regs[rs1]`.
  - Else if a valid broadcast this cycle matches `tag[rs1]` → tag 0, data = broadcast data (forward).
  - Else → tag `tag[rs1]`, data 0.
- Operand y: same rule on `rs2`; if `in_use_imm` then tag 0, data `in_imm`.
- `en_k` is a one-cycle pulse. Other slot-k outputs hold until the next issue to slot k.
- Writeback with tag T: every r≠0 with `tag[r]`=T gets `regs[r]`=data, `tag[r]`=0.
- Destination lock on accept: if `in_rd`≠0, `tag[in_rd]`=k+1. This overrides a same-cycle writeback clear, but the writeback data is still written.
- `ls_lock_valid` with rd≠0: `tag[ls_lock_rd]`=3. A same-cycle dispatch to the same rd wins, because the dispatched instruction is younger.
- Order within a cycle: writeback, then ls_lock, then dispatch lock. Operand reads use pre-update state plus forwarding.
- Register 0 is never locked or written.
- Two broadcasts with the same tag in one cycle cannot occur; no defined behaviour is required.

## Timing
- Reset: all `regs`=0, all `tag`=0, all `en_k`=0, and all slot outputs zero (tags 0). `in_ready`=0 while `rst`=1.
- `rst` asserted mid-issue: the pending `en` drops on the next edge; no tag survives.
- Latency: accept at edge N → `en_k` and operands valid from N to N+1.
- Back-to-back: with both slots free, consecutive instructions go to slot 0, then slot 1. A third instruction stalls until a slot's busy drops.
- A writeback in cycle N makes `regs` readable unlocked from cycle N+1. Forwarding covers cycle N itself.
- `rdy`=0: all state frozen, and `en_k` is forced to 0 on the next edge.

## Test plan
- Reset, then issue `add x3,x1,x2` with regs=0 → `en0`=1, `tagx0`=`tagy0`=0, `tagw0`=1, `addrw0`=3, `tag[3]`=1.
- Dependent pair: issue `x3=x1+x2`, then `x4=x3+imm 5` → slot1 gets `tagx1`=1, `tagy1`=0, `datay1`=5. Then pulse `wb_alu0` with data 0x1234 → `regs[3]`=0x1234, `tag[3]`=0.
- Forwarding: `tag[5]`=2; in the same cycle `wb_alu1_valid`=1 with data 0xDEAD and an instruction reads x5 → issued `tagx`=0, `datax`=0xDEAD.
- Full stall: `slot_busy0`=`slot_busy1`=1, `in_valid`=1 → `in_ready`=0, no `en`. Drop `slot_busy1` → next issue goes to slot 1.
- WAW/x0: dispatch to rd=7 while `ls_lock_rd`=7 in the same cycle → `tag[7]`=slot tag. Dispatch with rd=0 → `tag[0]` stays 0.
- Stale writeback: `tag[9]`=1, re-issue rd=9 to slot 1 (`tag[9]`=2), then `wb_alu0` → `regs[9]` and `tag[9]` unchanged.

Source files
------------

// File: rtl/alu_dispatch_if.sv
// Decoded-instruction valid/ready channel feeding the ALU issue stage.
interface alu_dispatch_if #(
  parameter int OP_W = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_pc;
  logic [OP_W-1:0] in_op;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic [31:0]     in_imm;
  logic            in_use_imm;

  modport master (
    output in_valid, in_pc, in_op, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_op, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
    output in_ready
  );
endinterface

// File: rtl/alu_dispatch.sv
// Issue stage for the two-slot ALU reservation station: operand read with tag
// tracking, slot allocation, and writeback snooping/forwarding.
module alu_dispatch #(
  parameter int OP_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  alu_dispatch_if.slave    in_if,
  input  logic             rdy_i,
  input  logic             slot_busy0_i,
  input  logic             slot_busy1_i,
  input  logic             wb_alu0_valid_i,
  input  logic [31:0]      wb_alu0_data_i,
  input  logic             wb_alu1_valid_i,
  input  logic [31:0]      wb_alu1_data_i,
  input  logic             wb_ls_valid_i,
  input  logic [31:0]      wb_ls_data_i,
  input  logic             ls_lock_valid_i,
  input  logic [4:0]       ls_lock_rd_i,
  output logic             en0_o,
  output logic [31:0]      pc0_o,
  output logic [OP_W-1:0]  op0_o,
  output logic [1:0]       tagx0_o,
  output logic [1:0]       tagy0_o,
  output logic [1:0]       tagw0_o,
  output logic [31:0]      datax0_o,
  output logic [31:0]      datay0_o,
  output logic [4:0]       addrw0_o,
  output logic             en1_o,
  output logic [31:0]      pc1_o,
  output logic [OP_W-1:0]  op1_o,
  output logic [1:0]       tagx1_o,
  output logic [1:0]       tagy1_o,
  output logic [1:0]       tagw1_o,
  output logic [31:0]      datax1_o,
  output logic [31:0]      datay1_o,
  output logic [4:0]       addrw1_o
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_ALU0 = 2'd1;
  localparam logic [1:0] TAG_ALU1 = 2'd2;
  localparam logic [1:0] TAG_LS   = 2'd3;

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
  } opnd_t;

  typedef struct packed {
    logic            en;
    logic [31:0]     pc;
    logic [OP_W-1:0] op;
    logic [1:0]      tagx;
    logic [1:0]      tagy;
    logic [1:0]      tagw;
    logic [31:0]     datax;
    logic [31:0]     datay;
    logic [4:0]      addrw;
  } slot_t;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [1:0]  tag_q  [32];
  logic [1:0]  tag_d  [32];
  slot_t       slot_q [2];
  slot_t       slot_d [2];

  logic             slot0_free;
  logic             slot1_free;
  logic             accept;
  logic             sel;
  logic [1:0]       dest_tag;
  logic [3:0]       bc_valid;
  logic [3:0][31:0] bc_data;
  opnd_t            opnd_x;
  opnd_t            opnd_y;

  // Broadcasts indexed by tag; entry 0 is never valid so unlocked registers never match.
  assign bc_valid = {wb_ls_valid_i, wb_alu1_valid_i, wb_alu0_valid_i, 1'b0};
  assign bc_data  = {wb_ls_data_i, wb_alu1_data_i, wb_alu0_data_i, 32'd0};

  // en_q also counts as busy: it covers the cycle before the RS raises its own busy.
  assign slot0_free     = !slot_busy0_i && !slot_q[0].en;
  assign slot1_free     = !slot_busy1_i && !slot_q[1].en;
  assign in_if.in_ready = rdy_i && !rst && (slot0_free || slot1_free);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign sel            = !slot0_free;
  assign dest_tag       = sel ? TAG_ALU1 : TAG_ALU0;

  function automatic opnd_t resolve(input logic [4:0]       addr,
                                    input logic [1:0]       t,
                                    input logic [31:0]      r,
                                    input logic [3:0]       bv,
                                    input logic [3:0][31:0] bd);
    opnd_t o;
    o = '0;
    if (addr == 5'd0)         o = '0;
    else if (t == TAG_NONE)   o.data = r;
    else if (bv[t])           o.data = bd[t];
    else                      o.tag  = t;
    return o;
  endfunction

  // NOTE: every variable below gets a full default first, so no path can leave one
  // unassigned and infer a latch; combinational logic uses blocking '=' throughout.
  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    slot_d = slot_q;
    slot_d[0].en = 1'b0;
    slot_d[1].en = 1'b0;

    opnd_x = resolve(in_if.in_rs1, tag_q[in_if.in_rs1], regs_q[in_if.in_rs1], bc_valid, bc_data);
    if (in_if.in_use_imm) begin
      opnd_y.tag  = TAG_NONE;
      opnd_y.data = in_if.in_imm;
    end else begin
      opnd_y = resolve(in_if.in_rs2, tag_q[in_if.in_rs2], regs_q[in_if.in_rs2], bc_valid, bc_data);
    end

    if (rdy_i) begin
      for (int r = 1; r < 32; r++) begin
        if (bc_valid[tag_q[r]]) begin
          regs_d[r] = bc_data[tag_q[r]];
          tag_d[r]  = TAG_NONE;
        end
      end
      if (ls_lock_valid_i && ls_lock_rd_i != 5'd0) begin
        tag_d[ls_lock_rd_i] = TAG_LS;
      end
    end

    // Dispatch lock comes last: the new instruction is the youngest writer of rd.
    if (accept) begin
      if (in_if.in_rd != 5'd0) begin
        tag_d[in_if.in_rd] = dest_tag;
      end
      slot_d[sel].en    = 1'b1;
      slot_d[sel].pc    = in_if.in_pc;
      slot_d[sel].op    = in_if.in_op;
      slot_d[sel].tagx  = opnd_x.tag;
      slot_d[sel].datax = opnd_x.data;
      slot_d[sel].tagy  = opnd_y.tag;
      slot_d[sel].datay = opnd_y.data;
      slot_d[sel].tagw  = dest_tag;
      slot_d[sel].addrw = in_if.in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is flop-based and must read zero after reset, so it is
      // cleared here rather than left to a RAM macro without reset.
      regs_q    <= '{default: '0};
      tag_q     <= '{default: TAG_NONE};
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      slot_q <= slot_d;
    end
  end

  assign en0_o    = slot_q[0].en;
  assign pc0_o    = slot_q[0].pc;
  assign op0_o    = slot_q[0].op;
  assign tagx0_o  = slot_q[0].tagx;
  assign tagy0_o  = slot_q[0].tagy;
  assign tagw0_o  = slot_q[0].tagw;
  assign datax0_o = slot_q[0].datax;
  assign datay0_o = slot_q[0].datay;
  assign addrw0_o = slot_q[0].addrw;

  assign en1_o    = slot_q[1].en;
  assign pc1_o    = slot_q[1].pc;
  assign op1_o    = slot_q[1].op;
  assign tagx1_o  = slot_q[1].tagx;
  assign tagy1_o  = slot_q[1].tagy;
  assign tagw1_o  = slot_q[1].tagw;
  assign datax1_o = slot_q[1].datax;
  assign datay1_o = slot_q[1].datay;
  assign addrw1_o = slot_q[1].addrw;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: vector table plus hand-written corner sequences,
// with issued operands compared through an expected-issue queue.
module tb_alu_dispatch;
  localparam int OP_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, busy0, busy1;
  logic wb0_v, wb1_v, wbl_v, lock_v;
  logic [31:0] wb0_d, wb1_d, wbl_d;
  logic [4:0]  lock_rd;

  logic en0, en1;
  logic [31:0] pc0, pc1, datax0, datay0, datax1, datay1;
  logic [OP_W-1:0] op0, op1;
  logic [1:0] tagx0, tagy0, tagw0, tagx1, tagy1, tagw1;
  logic [4:0] addrw0, addrw1;

  alu_dispatch_if #(.OP_W(OP_W)) ifc ();

  alu_dispatch #(.OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .in_if(ifc.slave), .rdy_i(rdy),
    .slot_busy0_i(busy0), .slot_busy1_i(busy1),
    .wb_alu0_valid_i(wb0_v), .wb_alu0_data_i(wb0_d),
    .wb_alu1_valid_i(wb1_v), .wb_alu1_data_i(wb1_d),
    .wb_ls_valid_i(wbl_v), .wb_ls_data_i(wbl_d),
    .ls_lock_valid_i(lock_v), .ls_lock_rd_i(lock_rd),
    .en0_o(en0), .pc0_o(pc0), .op0_o(op0), .tagx0_o(tagx0), .tagy0_o(tagy0),
    .tagw0_o(tagw0), .datax0_o(datax0), .datay0_o(datay0), .addrw0_o(addrw0),
    .en1_o(en1), .pc1_o(pc1), .op1_o(op1), .tagx1_o(tagx1), .tagy1_o(tagy1),
    .tagw1_o(tagw1), .datax1_o(datax1), .datay1_o(datay1), .addrw1_o(addrw1)
  );

  typedef struct packed {
    logic            slot;
    logic [31:0]     pc;
    logic [OP_W-1:0] op;
    logic [1:0]      tagx;
    logic [1:0]      tagy;
    logic [1:0]      tagw;
    logic [31:0]     datax;
    logic [31:0]     datay;
    logic [4:0]      addrw;
  } issue_t;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        use_imm;
    logic [31:0] imm;
    logic [2:0]  wb;        // {ls, alu1, alu0}
    logic [31:0] wb_data;
    logic        lock;
    logic [4:0]  lock_rd;
    logic        slot;
    logic [1:0]  tagx, tagy;
    logic [31:0] datax, datay;
  } vec_t;

  issue_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int seq = 0;
  logic [31:0]     cur_pc;
  logic [OP_W-1:0] cur_op;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Every issue pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    issue_t act, want;
    if (en0 === 1'b1 || en1 === 1'b1) begin
      check("single_en", 128'(en0 & en1), 128'(0));
      if (en1 === 1'b1) act = '{1'b1, pc1, op1, tagx1, tagy1, tagw1, datax1, datay1, addrw1};
      else              act = '{1'b0, pc0, op0, tagx0, tagy0, tagw0, datax0, datay0, addrw0};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %0h expected no issue", act);
      end else begin
        want = exp_q.pop_front();
        check("issue", 128'(act), 128'(want));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.in_valid = 1'b0; ifc.in_pc = '0; ifc.in_op = '0;
    ifc.in_rs1 = '0; ifc.in_rs2 = '0; ifc.in_rd = '0; ifc.in_imm = '0; ifc.in_use_imm = 1'b0;
    wb0_v = 1'b0; wb1_v = 1'b0; wbl_v = 1'b0; wb0_d = '0; wb1_d = '0; wbl_d = '0;
    lock_v = 1'b0; lock_rd = '0;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic use_imm, input logic [31:0] imm);
    seq++;
    cur_pc = 32'h1000 + 32'(seq * 4);
    cur_op = OP_W'(seq);
    ifc.in_valid = 1'b1; ifc.in_pc = cur_pc; ifc.in_op = cur_op;
    ifc.in_rs1 = rs1; ifc.in_rs2 = rs2; ifc.in_rd = rd;
    ifc.in_use_imm = use_imm; ifc.in_imm = imm;
  endtask

  task automatic push_exp(input logic slot, input logic [4:0] rd,
                          input logic [1:0] tx, input logic [31:0] dx,
                          input logic [1:0] ty, input logic [31:0] dy);
    issue_t e;
    e.slot = slot; e.pc = cur_pc; e.op = cur_op;
    e.tagx = tx; e.datax = dx; e.tagy = ty; e.datay = dy;
    e.tagw = slot ? 2'd2 : 2'd1; e.addrw = rd;
    exp_q.push_back(e);
  endtask

  function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic use_imm, input logic [31:0] imm,
                              input logic [2:0] wb, input logic [31:0] wb_data,
                              input logic lock, input logic [4:0] lock_rd, input logic slot,
                              input logic [1:0] tx, input logic [31:0] dx,
                              input logic [1:0] ty, input logic [31:0] dy);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.use_imm = use_imm; v.imm = imm;
    v.wb = wb; v.wb_data = wb_data; v.lock = lock; v.lock_rd = lock_rd; v.slot = slot;
    v.tagx = tx; v.datax = dx; v.tagy = ty; v.datay = dy;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    wb0_v = v.wb[0]; wb1_v = v.wb[1]; wbl_v = v.wb[2];
    wb0_d = v.wb_data; wb1_d = v.wb_data; wbl_d = v.wb_data;
    lock_v = v.lock; lock_rd = v.lock_rd;
    if (v.valid) drive_instr(v.rs1, v.rs2, v.rd, v.use_imm, v.imm);
    #1;
    if (v.valid) begin
      check("in_ready", 128'(ifc.in_ready), 128'(1));
      push_exp(v.slot, v.rd, v.tagx, v.datax, v.tagy, v.datay);
    end
    tick();
    idle_inputs();
  endtask

  vec_t vecs [13];

  initial begin
    // valid rs1 rs2 rd imm? imm | wb data | lock rd | slot tagx datax tagy datay
    vecs[0]  = mk(1, 1, 2, 3, 0, 0,            3'b000, 0,            0, 0, 0, 0, 0,            0, 0);
    vecs[1]  = mk(1, 3, 0, 4, 1, 5,            3'b000, 0,            0, 0, 1, 1, 0,            0, 5);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,            3'b001, 32'h1234,     0, 0, 0, 0, 0,            0, 0);
    vecs[3]  = mk(1, 3, 4, 0, 0, 0,            3'b000, 0,            0, 0, 0, 0, 32'h1234,     2, 0);
    vecs[4]  = mk(1, 0, 0, 5, 0, 0,            3'b000, 0,            0, 0, 1, 0, 0,            0, 0);
    vecs[5]  = mk(1, 5, 4, 6, 0, 0,            3'b010, 32'hDEAD,     0, 0, 0, 0, 32'hDEAD,     0, 32'hDEAD);
    vecs[6]  = mk(1, 5, 0, 7, 1, 32'hFFFFFFFF, 3'b000, 0,            1, 7, 1, 0, 32'hDEAD,     0, 32'hFFFFFFFF);
    vecs[7]  = mk(1, 7, 6, 0, 0, 0,            3'b000, 0,            0, 0, 0, 2, 0,            1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0,            3'b000, 0,            0, 0, 1, 0, 0,            0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,            3'b000, 0,            1, 8, 0, 0, 0,            0, 0);
    vecs[10] = mk(1, 8, 7, 0, 0, 0,            3'b100, 32'h55,       0, 0, 0, 0, 32'h55,       2, 0);
    vecs[11] = mk(1, 7, 0, 7, 0, 0,            3'b010, 32'h77,       0, 0, 1, 0, 32'h77,       0, 0);
    vecs[12] = mk(1, 7, 8, 0, 0, 0,            3'b000, 0,            0, 0, 0, 2, 0,            0, 32'h55);

    idle_inputs();
    rdy = 1'b1; busy0 = 1'b0; busy1 = 1'b0; rst = 1'b1;
    drive_instr(1, 2, 3, 0, 0);
    repeat (2) tick();
    check("ready_in_reset", 128'(ifc.in_ready), 128'(0));
    check("en_after_reset", 128'({en0, en1}), 128'(0));
    check("slot0_after_reset", 128'({pc0, op0, tagx0, tagy0, tagw0, datax0, datay0, addrw0}), 128'(0));
    check("slot1_after_reset", 128'({pc1, op1, tagx1, tagy1, tagw1, datax1, datay1, addrw1}), 128'(0));
    rst = 1'b0;
    idle_inputs();
    tick();

    for (int i = 0; i < 13; i++) apply(vecs[i]);

    // Both slots busy: hold the instruction, then release slot 1 only.
    busy0 = 1'b1; busy1 = 1'b1;
    drive_instr(3, 6, 11, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ready_full_stall", 128'(ifc.in_ready), 128'(0));
      tick();
    end
    busy1 = 1'b0;
    #1;
    check("ready_after_release", 128'(ifc.in_ready), 128'(1));
    push_exp(1, 11, 0, 32'h1234, 1, 0);
    tick();
    idle_inputs();
    busy0 = 1'b0;
    repeat (2) tick();

    // Stale writeback: x9 relocked by slot 1 must ignore the ALU0 result.
    apply(mk(1, 0, 0, 9, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 9, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 3'b001, 32'hBAD, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 9, 6, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2, 0, 0, 32'hBAD));

    // rdy low right after an issue: en must drop, writeback and lock are ignored.
    rdy = 1'b0;
    drive_instr(9, 3, 12, 0, 0);
    wb1_v = 1'b1; wb1_d = 32'h999; lock_v = 1'b1; lock_rd = 5'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ready_when_not_rdy", 128'(ifc.in_ready), 128'(0));
      tick();
    end
    rdy = 1'b1;
    idle_inputs();
    apply(mk(1, 9, 3, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2, 0, 0, 32'h1234));
    apply(mk(0, 0, 0, 0, 0, 0, 3'b010, 32'h4242, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 9, 11, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h4242, 0, 32'h4242));
    tick();

    // Reset while an issue is pending: en drops and all tags and registers clear.
    apply(mk(1, 9, 0, 10, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h4242, 0, 0));
    rst = 1'b1;
    #1;
    check("ready_mid_reset", 128'(ifc.in_ready), 128'(0));
    tick();
    check("en0_after_mid_reset", 128'({en0, en1}), 128'(0));
    check("slot0_after_mid_reset", 128'({pc0, op0, tagw0, datax0, addrw0}), 128'(0));
    rst = 1'b0;
    apply(mk(1, 10, 9, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("drain", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
